// File: rtl/mp_addsub_seq_pkg.sv
// Shared constants for the multi-precision add/sub sequencer.
// Holds the state and op encodings, the limb width and a full-adder helper.
package mp_addsub_seq_pkg;

    localparam int LIMB_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Returns {carry, sum} of a single-bit full adder.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic [1:0] res;
        res[0] = x ^ y ^ ci;
        res[1] = (x & y) | (x & ci) | (y & ci);
        return res;
    endfunction

endpackage

// File: rtl/mp_addsub_seq_if.sv
// Operand request / result handshake bundle for mp_addsub_seq.
// The sequencer uses the slave view; the producer/consumer side uses master.
interface mp_addsub_seq_if #(
    parameter int NBYTES = 4
);
    import mp_addsub_seq_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic                       op;
    logic [LIMB_W*NBYTES-1:0]   a;
    logic [LIMB_W*NBYTES-1:0]   b;
    logic                       res_valid;
    logic                       res_ready;
    logic [LIMB_W*NBYTES-1:0]   r;
    logic                       cout;
    logic                       of;

    modport slave (
        input  in_valid, op, a, b, res_ready,
        output in_ready, res_valid, r, cout, of
    );

    modport master (
        output in_valid, op, a, b, res_ready,
        input  in_ready, res_valid, r, cout, of
    );

endinterface

// File: rtl/mp_addsub_seq_slice.sv
// Combinational 8-bit add/sub slice: y is conditionally inverted by op and
// rippled through full adders; also reports the limb-level signed overflow.
module byte_addsub_slice
    import mp_addsub_seq_pkg::*;
(
    input  logic [LIMB_W-1:0] i_x,
    input  logic [LIMB_W-1:0] i_y,
    input  logic              i_ci,
    input  logic              i_op,
    output logic [LIMB_W-1:0] o_s,
    output logic              o_co,
    output logic              o_ovf
);

    logic [LIMB_W-1:0] w_y;
    logic [LIMB_W:0]   w_c;
    logic [1:0]        w_fa;

    // Ripple-carry chain over the conditioned y operand.
    always_comb begin
        w_y    = i_y ^ {LIMB_W{i_op}};
        w_c    = '0;
        w_c[0] = i_ci;
        w_fa   = 2'b00;
        o_s    = '0;
        for (int i = 0; i < LIMB_W; i++) begin
            w_fa       = full_add(i_x[i], w_y[i], w_c[i]);
            o_s[i]     = w_fa[0];
            w_c[i+1]   = w_fa[1];
        end
        o_co  = w_c[LIMB_W];
        o_ovf = (i_x[LIMB_W-1] == w_y[LIMB_W-1]) & (o_s[LIMB_W-1] != i_x[LIMB_W-1]);
    end

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/sub sequencer: one 8-bit slice reused LSB-first over
// NBYTES cycles with the carry held in a register between limbs.
module mp_addsub_seq
    import mp_addsub_seq_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    mp_addsub_seq_if.slave    bus
);

    localparam int W = LIMB_W * NBYTES;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [W-1:0]        r_sa;
    logic [W-1:0]        r_sb;
    logic [W-1:0]        r_res;
    logic                r_op;
    logic                r_c;
    logic                r_cout;
    logic                r_of;
    logic [CW-1:0]       r_cnt;

    logic                w_in_ready;
    logic                w_res_valid;
    logic                w_last;
    logic [LIMB_W-1:0]   w_s;
    logic                w_co;
    logic                w_ovf;

    byte_addsub_slice u_slice (
        .i_x   (r_sa[LIMB_W-1:0]),
        .i_y   (r_sb[LIMB_W-1:0]),
        .i_ci  (r_c),
        .i_op  (r_op),
        .o_s   (w_s),
        .o_co  (w_co),
        .o_ovf (w_ovf)
    );

    assign w_last = (r_cnt == CW'(NBYTES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, limb-serial shift and final carry/overflow capture.
    // The carry register starts at op so subtraction becomes a + ~b + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_res  <= '0;
            r_op   <= OP_ADD;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_of   <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == ST_IDLE && bus.in_valid) begin
            r_sa  <= bus.a;
            r_sb  <= bus.b;
            r_op  <= bus.op;
            r_c   <= bus.op;
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_c   <= w_co;
            r_sa  <= r_sa >> LIMB_W;
            r_sb  <= r_sb >> LIMB_W;
            r_res <= (r_res >> LIMB_W) | (W'(w_s) << (W - LIMB_W));
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_co;
                r_of   <= w_ovf;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.res_valid = w_res_valid;
    assign bus.r         = r_res;
    assign bus.cout      = r_cout;
    assign bus.of        = r_of;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Directed bench for mp_addsub_seq with a 4-limb and a 1-limb instance.
module tb_mp_addsub_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mp_addsub_seq_if #(.NBYTES(4)) if4 ();
    mp_addsub_seq_if #(.NBYTES(1)) if1 ();

    mp_addsub_seq #(.NBYTES(4), .CW(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    mp_addsub_seq #(.NBYTES(1), .CW(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at the first negedge after an accept edge on the 4-limb DUT.
    task automatic wait4(input string tag, input logic [31:0] er, input logic ec, input logic eo);
        int lat;
        lat = 1;
        while (!if4.res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},  64'(lat),       64'd5);
        chk({tag, "_r"},    64'(if4.r),     64'(er));
        chk({tag, "_cout"}, 64'(if4.cout),  64'(ec));
        chk({tag, "_of"},   64'(if4.of),    64'(eo));
    endtask

    task automatic run4(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec, input logic eo);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(if4.in_ready), 64'd1);
        if4.in_valid = 1'b1;
        if4.op       = op;
        if4.a        = a;
        if4.b        = b;
        @(negedge clk);
        if4.in_valid = 1'b0;
        wait4(tag, er, ec, eo);
        if4.res_ready = 1'b1;
        @(negedge clk);
        if4.res_ready = 1'b0;
        chk({tag, "_drop"}, 64'(if4.res_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int last;
        int n_acc;

        rst = 1'b1;
        if4.in_valid = 1'b0; if4.op = 1'b0; if4.a = '0; if4.b = '0; if4.res_ready = 1'b0;
        if1.in_valid = 1'b0; if1.op = 1'b0; if1.a = '0; if1.b = '0; if1.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  64'(if4.in_ready),  64'd1);
        chk("rst_res_valid", 64'(if4.res_valid), 64'd0);
        chk("rst_r",         64'(if4.r),         64'd0);
        chk("rst_cout",      64'(if4.cout),      64'd0);
        chk("rst_of",        64'(if4.of),        64'd0);

        run4("add_ovf",  1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        run4("sub_brw",  1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run4("sub_ovf",  1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run4("add_carry",1'b0, 32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0, 1'b0);
        run4("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);

        // Backpressure: result must hold while the consumer stalls.
        @(negedge clk);
        if4.in_valid = 1'b1; if4.op = 1'b0; if4.a = 32'h1234_0000; if4.b = 32'h0000_5678;
        @(negedge clk);
        if4.in_valid = 1'b0;
        wait4("bp", 32'h1234_5678, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if4.in_valid = i[0];
            if4.op       = 1'b1;
            if4.a        = 32'hFFFF_0000 + 32'(i);
            if4.b        = 32'h0000_00F0;
            @(negedge clk);
            chk("bp_r",         64'(if4.r),         64'h1234_5678);
            chk("bp_cout",      64'(if4.cout),      64'd0);
            chk("bp_of",        64'(if4.of),        64'd0);
            chk("bp_in_ready",  64'(if4.in_ready),  64'd0);
            chk("bp_res_valid", 64'(if4.res_valid), 64'd1);
        end
        if4.in_valid = 1'b1; if4.op = 1'b0; if4.a = 32'h0000_0002; if4.b = 32'h0000_0003;
        if4.res_ready = 1'b1;
        @(negedge clk);
        if4.res_ready = 1'b0;
        chk("bp_hs_in_ready",  64'(if4.in_ready),  64'd1);
        chk("bp_hs_res_valid", 64'(if4.res_valid), 64'd0);
        @(negedge clk);
        if4.in_valid = 1'b0;
        wait4("bp_next", 32'h0000_0005, 1'b0, 1'b0);
        if4.res_ready = 1'b1;
        @(negedge clk);
        if4.res_ready = 1'b0;

        // Reset one cycle after accept aborts the operation.
        if4.in_valid = 1'b1; if4.op = 1'b0; if4.a = 32'hFFFF_FFFF; if4.b = 32'hFFFF_FFFF;
        @(negedge clk);
        if4.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_in_ready",  64'(if4.in_ready),  64'd1);
        chk("mid_res_valid", 64'(if4.res_valid), 64'd0);
        chk("mid_r",         64'(if4.r),         64'd0);
        run4("post_rst", 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);

        // Single-limb instance: one RUN cycle.
        @(negedge clk);
        if1.in_valid = 1'b1; if1.op = 1'b0; if1.a = 8'h7F; if1.b = 8'h01;
        @(negedge clk);
        if1.in_valid = 1'b0;
        lat = 1;
        while (!if1.res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("n1_lat",  64'(lat),      64'd2);
        chk("n1_r",    64'(if1.r),    64'h80);
        chk("n1_of",   64'(if1.of),   64'd1);
        chk("n1_cout", 64'(if1.cout), 64'd0);
        if1.res_ready = 1'b1;
        @(negedge clk);

        // Back-to-back with res_ready held high: one accept every 3 cycles.
        if1.in_valid = 1'b1; if1.a = 8'h10; if1.b = 8'h22;
        last  = -1;
        n_acc = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (if1.in_ready) begin
                if (last >= 0) chk("b2b_gap", 64'(cyc - last), 64'd3);
                last = cyc;
                n_acc++;
            end
            if (if1.res_valid) chk("b2b_r", 64'(if1.r), 64'h32);
            @(negedge clk);
        end
        chk("b2b_count", 64'(n_acc), 64'd5);
        if1.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        if1.res_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
